// File: rtl/hazard_unit_if.sv
// Pipeline-state inputs and front-end control outputs of the hazard unit.
interface hazard_unit_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       IDRsReg;
  logic [4:0]       IDRtReg;
  logic             IDUsesRt;
  logic             IDIsJr;
  logic             EXMemRead;
  logic             EXRegWrite;
  logic [4:0]       EXDestReg;
  logic             MEMMemRead;
  logic [4:0]       MEMDestReg;
  logic             EXRedirect;
  logic             CntClr;
  logic             PCWrite;
  logic             IFIDWrite;
  logic             IFIDFlush;
  logic             IDEXFlush;
  logic [CNT_W-1:0] StallCount;
  logic [CNT_W-1:0] FlushCount;

  modport master (
    output IDRsReg, IDRtReg, IDUsesRt, IDIsJr, EXMemRead, EXRegWrite, EXDestReg,
           MEMMemRead, MEMDestReg, EXRedirect, CntClr,
    input  PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, StallCount, FlushCount
  );

  modport slave (
    input  IDRsReg, IDRtReg, IDUsesRt, IDIsJr, EXMemRead, EXRegWrite, EXDestReg,
           MEMMemRead, MEMDestReg, EXRedirect, CntClr,
    output PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, StallCount, FlushCount
  );
endinterface

// File: rtl/hazard_unit.sv
// Front-end stall/flush control: load-use and jr hazards, EX redirects,
// plus saturating stall/flush event counters.
module hazard_unit #(
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_unit_if.slave hz
);
  typedef enum logic {RUN, STALL} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [1:0]       left_q, left_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic ex_rs, ex_rt, mem_rs;
  logic lu, jr1, jr2, jrm;
  logic stall, pc_we, ifid_we, ifid_fl, idex_fl;

  // $0 is never a real producer, so matches against it are suppressed.
  assign ex_rs  = (hz.EXDestReg  != 5'd0) && (hz.EXDestReg  == hz.IDRsReg);
  assign ex_rt  = (hz.EXDestReg  != 5'd0) && (hz.EXDestReg  == hz.IDRtReg);
  assign mem_rs = (hz.MEMDestReg != 5'd0) && (hz.MEMDestReg == hz.IDRsReg);

  assign lu  = hz.EXMemRead & (ex_rs | (hz.IDUsesRt & ex_rt));
  assign jr1 = hz.IDIsJr & hz.EXRegWrite & ex_rs & ~hz.EXMemRead;
  assign jr2 = hz.IDIsJr & hz.EXMemRead & ex_rs;
  assign jrm = hz.IDIsJr & hz.MEMMemRead & mem_rs;

  always_comb begin
    state_d = state_q;
    left_d  = left_q;
    stall   = 1'b0;
    pc_we   = 1'b1;
    ifid_we = 1'b1;
    ifid_fl = 1'b0;
    idex_fl = 1'b0;
    // The ID instruction is wrong-path on a redirect, so its hazards are moot.
    if (hz.EXRedirect) begin
      ifid_fl = 1'b1;
      idex_fl = 1'b1;
      state_d = RUN;
      left_d  = 2'd0;
    end else begin
      case (state_q)
        RUN: begin
          if (jr2) begin
            stall   = 1'b1;
            state_d = STALL;
            left_d  = 2'd1;
          end else if (lu | jr1 | jrm) begin
            stall = 1'b1;
          end
        end
        STALL: begin
          stall  = 1'b1;
          left_d = left_q - 2'd1;
          if (left_q <= 2'd1) begin
            state_d = RUN;
            left_d  = 2'd0;
          end
        end
        default: begin
          state_d = RUN;
          left_d  = 2'd0;
        end
      endcase
    end
    if (stall) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      idex_fl = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hz.CntClr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (!pc_we && stall_cnt_q != CNT_MAX)
        stall_cnt_d = stall_cnt_q + CNT_ONE;
      if (hz.EXRedirect && flush_cnt_q != CNT_MAX)
        flush_cnt_d = flush_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      left_q      <= 2'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      left_q      <= left_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.PCWrite    = pc_we;
  assign hz.IFIDWrite  = ifid_we;
  assign hz.IFIDFlush  = ifid_fl;
  assign hz.IDEXFlush  = idex_fl;
  assign hz.StallCount = stall_cnt_q;
  assign hz.FlushCount = flush_cnt_q;
endmodule

// File: tb/tb_hazard_unit.sv
// Directed and randomized checks of hazard_unit against a cycle-level
// model that tracks outstanding stall cycles and event counts as integers.
module tb_hazard_unit;
  localparam int CW  = 2;
  localparam int MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_unit_if #(.CNT_W(CW)) hz ();
  hazard_unit #(.CNT_W(CW)) u_dut (.clk(clk), .rst_n(rst_n), .hz(hz.slave));

  int checks = 0;
  int errors = 0;
  int m_pend = 0;
  int m_sc   = 0;
  int m_fc   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_in();
    hz.IDRsReg = 5'd0; hz.IDRtReg = 5'd0; hz.IDUsesRt = 1'b0; hz.IDIsJr = 1'b0;
    hz.EXMemRead = 1'b0; hz.EXRegWrite = 1'b0; hz.EXDestReg = 5'd0;
    hz.MEMMemRead = 1'b0; hz.MEMDestReg = 5'd0; hz.EXRedirect = 1'b0; hz.CntClr = 1'b0;
  endtask

  function automatic bit same(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

  // One clock cycle: inputs are already applied; check outputs, then advance model.
  task automatic cyc(input string tag);
    logic [3:0] exp;
    bit         stl, lu, jr1, jr2, jrm;
    int         npend;
    #1;
    lu  = hz.EXMemRead && (same(hz.EXDestReg, hz.IDRsReg) ||
                           (hz.IDUsesRt && same(hz.EXDestReg, hz.IDRtReg)));
    jr1 = hz.IDIsJr && hz.EXRegWrite && !hz.EXMemRead && same(hz.EXDestReg, hz.IDRsReg);
    jr2 = hz.IDIsJr && hz.EXMemRead && same(hz.EXDestReg, hz.IDRsReg);
    jrm = hz.IDIsJr && hz.MEMMemRead && same(hz.MEMDestReg, hz.IDRsReg);
    stl   = 1'b0;
    npend = m_pend;
    if (hz.EXRedirect)  npend = 0;
    else if (m_pend > 0) begin stl = 1'b1; npend = m_pend - 1; end
    else if (jr2)        begin stl = 1'b1; npend = 1; end
    else if (lu || jr1 || jrm) stl = 1'b1;
    if (hz.EXRedirect) exp = 4'b1111;
    else if (stl)      exp = 4'b0001;
    else               exp = 4'b1100;
    chk({tag, ".ctl"}, 32'({hz.PCWrite, hz.IFIDWrite, hz.IFIDFlush, hz.IDEXFlush}), 32'(exp));
    chk({tag, ".scnt"}, 32'(hz.StallCount), 32'(m_sc));
    chk({tag, ".fcnt"}, 32'(hz.FlushCount), 32'(m_fc));
    chk({tag, ".nofl_stall"}, 32'(hz.IFIDFlush & ~hz.IFIDWrite), 32'd0);
    @(posedge clk);
    if (hz.CntClr) begin
      m_sc = 0; m_fc = 0;
    end else begin
      if (stl && m_sc < MAX) m_sc++;
      if (hz.EXRedirect && m_fc < MAX) m_fc++;
    end
    m_pend = npend;
    @(negedge clk);
  endtask

  task automatic clear_counters();
    clr_in(); hz.CntClr = 1'b1; cyc("clr"); clr_in();
  endtask

  initial begin
    clr_in();
    #2;
    chk("rst.ctl", 32'({hz.PCWrite, hz.IFIDWrite, hz.IFIDFlush, hz.IDEXFlush}), 32'hC);
    chk("rst.scnt", 32'(hz.StallCount), 32'd0);
    chk("rst.fcnt", 32'(hz.FlushCount), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // back-to-back load-use
    hz.EXMemRead = 1'b1; hz.EXDestReg = 5'd8; hz.IDRsReg = 5'd8; hz.IDRtReg = 5'd1;
    cyc("lu");
    clr_in(); hz.IDRsReg = 5'd8; hz.IDRtReg = 5'd1;
    cyc("lu_adv");
    chk("lu.scnt1", 32'(hz.StallCount), 32'd1);

    // register 0 and rt gating
    clr_in(); hz.EXMemRead = 1'b1; cyc("r0");
    hz.EXDestReg = 5'd8; hz.IDRtReg = 5'd8; hz.IDRsReg = 5'd3; cyc("rt_unused");
    hz.IDUsesRt = 1'b1; cyc("rt_used");

    // jr after ALU writer
    clr_in(); hz.IDIsJr = 1'b1; hz.IDRsReg = 5'd5; hz.EXRegWrite = 1'b1; hz.EXDestReg = 5'd5;
    cyc("jr1");
    clr_in(); hz.IDIsJr = 1'b1; hz.IDRsReg = 5'd5; cyc("jr1_adv");

    // jr after load: two stalls
    clear_counters();
    hz.EXMemRead = 1'b1; hz.EXDestReg = 5'd31; hz.IDIsJr = 1'b1; hz.IDRsReg = 5'd31;
    cyc("jr2");
    clr_in(); hz.IDIsJr = 1'b1; hz.IDRsReg = 5'd31; hz.MEMMemRead = 1'b1; hz.MEMDestReg = 5'd31;
    cyc("jr2_s2");
    clr_in(); hz.IDIsJr = 1'b1; hz.IDRsReg = 5'd31; cyc("jr2_adv");
    chk("jr2.scnt2", 32'(hz.StallCount), 32'd2);

    // redirect during STALL
    clear_counters();
    hz.EXMemRead = 1'b1; hz.EXDestReg = 5'd31; hz.IDIsJr = 1'b1; hz.IDRsReg = 5'd31;
    cyc("rdst_jr2");
    clr_in(); hz.EXRedirect = 1'b1; cyc("rdst_flush");
    clr_in(); cyc("rdst_run");
    chk("rdst.scnt", 32'(hz.StallCount), 32'd1);
    chk("rdst.fcnt", 32'(hz.FlushCount), 32'd1);

    // redirect with load-use in the same cycle
    clr_in(); hz.EXRedirect = 1'b1; hz.EXMemRead = 1'b1; hz.EXDestReg = 5'd4; hz.IDRsReg = 5'd4;
    cyc("rd_lu");
    clr_in(); cyc("rd_lu_after");
    chk("rd_lu.scnt", 32'(hz.StallCount), 32'd1);

    // saturation and clear priority
    clear_counters();
    hz.EXMemRead = 1'b1; hz.EXDestReg = 5'd9; hz.IDRsReg = 5'd9;
    for (int i = 0; i < 5; i++) cyc("sat");
    chk("sat.scnt", 32'(hz.StallCount), 32'd3);
    hz.CntClr = 1'b1; cyc("sat_clr");
    hz.CntClr = 1'b0;
    chk("sat.cleared", 32'(hz.StallCount), 32'd0);
    clr_in(); cyc("sat_end");

    // asynchronous reset mid-STALL
    hz.EXMemRead = 1'b1; hz.EXDestReg = 5'd31; hz.IDIsJr = 1'b1; hz.IDRsReg = 5'd31;
    cyc("ar_jr2");
    clr_in();
    rst_n = 1'b0;
    #1;
    chk("ar.scnt", 32'(hz.StallCount), 32'd0);
    chk("ar.fcnt", 32'(hz.FlushCount), 32'd0);
    chk("ar.pcw", 32'(hz.PCWrite), 32'd1);
    m_pend = 0; m_sc = 0; m_fc = 0;
    #1 rst_n = 1'b1;
    cyc("ar_run");

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      hz.IDRsReg    = 5'($urandom_range(0, 3));
      hz.IDRtReg    = 5'($urandom_range(0, 3));
      hz.IDUsesRt   = 1'($urandom_range(0, 1));
      hz.IDIsJr     = ($urandom_range(0, 2) == 0);
      hz.EXMemRead  = 1'($urandom_range(0, 1));
      hz.EXRegWrite = 1'($urandom_range(0, 1));
      hz.EXDestReg  = 5'($urandom_range(0, 3));
      hz.MEMMemRead = 1'($urandom_range(0, 1));
      hz.MEMDestReg = 5'($urandom_range(0, 3));
      hz.EXRedirect = ($urandom_range(0, 7) == 0);
      hz.CntClr     = ($urandom_range(0, 15) == 0);
      cyc("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
